// File: rtl/sae_decrypt_stream.sv
// Receiver-side stream controller for the SAE core.
// Accepts ciphertext bytes, feeds them one at a time to an external sae core
// in decrypt mode with a latched private key, and queues the recovered
// plaintext in a small FIFO with its own valid/ready handshake.
module sae_decrypt_stream #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  priv_key,
  input  logic        ct_valid,
  output logic        ct_ready,
  input  logic [7:0]  ct_data,
  input  logic        ct_last,
  output logic        pt_valid,
  input  logic        pt_ready,
  output logic [7:0]  pt_data,
  output logic        pt_last,
  output logic [1:0]  core_mode,
  output logic [7:0]  core_data_input,
  output logic [7:0]  core_key_input,
  output logic        core_inputs_valid,
  input  logic [7:0]  core_data_output,
  input  logic        core_output_ready,
  input  logic        core_err_invalid_ctxt_char,
  input  logic        core_err_invalid_seckey,
  output logic        busy,
  output logic        done,
  output logic        err_char,
  output logic        err_key,
  output logic        err_timeout,
  output logic [15:0] char_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_FIRE,
    ST_WAIT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      key_q, key_d;
  logic [7:0]      data_q, data_d;
  logic            last_q, last_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            err_char_q, err_char_d;
  logic            err_key_q, err_key_d;
  logic            err_timeout_q, err_timeout_d;
  logic [15:0]     char_count_q, char_count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [8:0]      mem_q [FIFO_DEPTH];
  logic [8:0]      head;
  logic            push;
  logic            pop;
  logic            fifo_clear;

  // FSM next state, handshake strobes and FIFO control.
  // NOTE: every signal gets a default before the case statement so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    data_d        = data_q;
    last_d        = last_q;
    wait_d        = wait_q;
    err_char_d    = err_char_q;
    err_key_d     = err_key_q;
    err_timeout_d = err_timeout_q;
    char_count_d  = char_count_q;
    ct_ready          = 1'b0;
    core_inputs_valid = 1'b0;
    push              = 1'b0;
    fifo_clear        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d         = priv_key;
          err_char_d    = 1'b0;
          err_key_d     = 1'b0;
          err_timeout_d = 1'b0;
          char_count_d  = 16'd0;
          fifo_clear    = 1'b1;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ct_ready = (count_q < CW'(FIFO_DEPTH));
        if (ct_valid && ct_ready) begin
          data_d  = ct_data;
          last_d  = ct_last;
          state_d = ST_FIRE;
        end
      end
      ST_FIRE: begin
        core_inputs_valid = 1'b1;
        wait_d            = '0;
        state_d           = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_output_ready) begin
          if (core_err_invalid_seckey) begin
            err_key_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            if (core_err_invalid_ctxt_char) begin
              err_char_d = 1'b1;
            end else begin
              push = 1'b1;
              if (char_count_q != 16'hFFFF) char_count_d = char_count_q + 16'd1;
            end
            state_d = last_q ? ST_DRAIN : ST_ISSUE;
          end
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = ST_DONE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      ST_DRAIN: begin
        if (count_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO pointer and occupancy update; a new message empties the FIFO.
  always_comb begin
    pop      = pt_valid && pt_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control and status registers; reset is asserted when rst_n is high.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q       <= ST_IDLE;
      key_q         <= '0;
      data_q        <= '0;
      last_q        <= 1'b0;
      wait_q        <= '0;
      err_char_q    <= 1'b0;
      err_key_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      char_count_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      data_q        <= data_d;
      last_q        <= last_d;
      wait_q        <= wait_d;
      err_char_q    <= err_char_d;
      err_key_q     <= err_key_d;
      err_timeout_q <= err_timeout_d;
      char_count_q  <= char_count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Plaintext storage written on push.
  // NOTE: the storage array has no reset; emptiness is tracked by count_q and
  // the read port is masked while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {last_q, core_data_output};
  end

  assign head              = mem_q[rd_ptr_q];
  assign pt_valid          = (count_q != '0);
  assign pt_data           = pt_valid ? head[7:0] : 8'h00;
  assign pt_last           = pt_valid & head[8];
  assign core_mode         = (state_q == ST_FIRE || state_q == ST_WAIT) ? 2'b11 : 2'b00;
  assign core_data_input   = data_q;
  assign core_key_input    = key_q;
  assign busy              = (state_q != ST_IDLE);
  assign done              = (state_q == ST_DONE);
  assign err_char          = err_char_q;
  assign err_key           = err_key_q;
  assign err_timeout       = err_timeout_q;
  assign char_count        = char_count_q;

endmodule

// File: tb/tb_sae_decrypt_stream.sv
// Self-checking bench for sae_decrypt_stream: a responder core model
// (pt = ct ^ key, answer in the cycle after the strobe), an expected-plaintext
// queue compared on every pop, and directed scenarios with literal checks.
module tb_sae_decrypt_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  priv_key;
  logic        ct_valid;
  logic        ct_ready;
  logic [7:0]  ct_data;
  logic        ct_last;
  logic        pt_valid;
  logic        pt_ready;
  logic [7:0]  pt_data;
  logic        pt_last;
  logic [1:0]  core_mode;
  logic [7:0]  core_data_input;
  logic [7:0]  core_key_input;
  logic        core_inputs_valid;
  logic [7:0]  core_data_output;
  logic        core_output_ready;
  logic        core_err_invalid_ctxt_char;
  logic        core_err_invalid_seckey;
  logic        busy;
  logic        done;
  logic        err_char;
  logic        err_key;
  logic        err_timeout;
  logic [15:0] char_count;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef enum {B_OK, B_CTXT, B_KEY, B_NONE} behav_t;
  behav_t     behav = B_OK;
  int         err_at = 0;
  int         strobe_idx;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  always #5 clk = ~clk;

  sae_decrypt_stream #(.FIFO_DEPTH(8), .TIMEOUT(15)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .start                      (start),
    .priv_key                   (priv_key),
    .ct_valid                   (ct_valid),
    .ct_ready                   (ct_ready),
    .ct_data                    (ct_data),
    .ct_last                    (ct_last),
    .pt_valid                   (pt_valid),
    .pt_ready                   (pt_ready),
    .pt_data                    (pt_data),
    .pt_last                    (pt_last),
    .core_mode                  (core_mode),
    .core_data_input            (core_data_input),
    .core_key_input             (core_key_input),
    .core_inputs_valid          (core_inputs_valid),
    .core_data_output           (core_data_output),
    .core_output_ready          (core_output_ready),
    .core_err_invalid_ctxt_char (core_err_invalid_ctxt_char),
    .core_err_invalid_seckey    (core_err_invalid_seckey),
    .busy                       (busy),
    .done                       (done),
    .err_char                   (err_char),
    .err_key                    (err_key),
    .err_timeout                (err_timeout),
    .char_count                 (char_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core model: one answer per decrypt strobe, in the following cycle.
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      core_output_ready          <= 1'b0;
      core_data_output           <= 8'h00;
      core_err_invalid_ctxt_char <= 1'b0;
      core_err_invalid_seckey    <= 1'b0;
      strobe_idx                 <= 0;
    end else begin
      core_output_ready          <= 1'b0;
      core_err_invalid_ctxt_char <= 1'b0;
      core_err_invalid_seckey    <= 1'b0;
      if (start && !busy) strobe_idx <= 0;
      if (core_inputs_valid && core_mode == 2'b11) begin
        strobe_idx <= strobe_idx + 1;
        if (behav != B_NONE) begin
          core_output_ready          <= 1'b1;
          core_data_output           <= core_data_input ^ core_key_input;
          core_err_invalid_ctxt_char <= (behav == B_CTXT) && (strobe_idx == err_at);
          core_err_invalid_seckey    <= (behav == B_KEY) && (strobe_idx == err_at);
        end
      end
    end
  end

  // Count done pulses.
  always @(negedge clk) begin
    if (!rst_n && done) done_cnt++;
  end

  // Compare every popped plaintext byte against the expected queue.
  always @(negedge clk) begin
    if (!rst_n && pt_valid && pt_ready) begin
      got_q.push_back({pt_last, pt_data});
      if (exp_q.size() == 0) begin
        check("pt_unexpected", {pt_last, pt_data}, 64'h1FF);
      end else begin
        check("pt_byte", {pt_last, pt_data}, exp_q.pop_front());
      end
    end
  end

  function automatic logic [63:0] out_vec();
    return {ct_ready, pt_valid, pt_data, pt_last, core_mode, core_data_input,
            core_key_input, core_inputs_valid, busy, done, err_char, err_key,
            err_timeout, char_count};
  endfunction

  task automatic start_msg(input logic [7:0] key);
    @(negedge clk);
    start = 1'b1;
    priv_key = key;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte; returns at the negedge right after the accepting edge.
  task automatic send_byte(input logic [7:0] key, input logic [7:0] d,
                           input logic last, input logic expect_push);
    int n = 0;
    ct_valid = 1'b1;
    ct_data  = d;
    ct_last  = last;
    while (!ct_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ct_accept_in_time", n < 300, 1);
    if (expect_push) exp_q.push_back({last, d ^ key});
    @(negedge clk);
    ct_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    int base = done_cnt;
    while (done_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, done_cnt != base, 1);
    @(negedge clk);
  endtask

  task automatic clear_scoreboard();
    exp_q.delete();
    got_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b1;
    start = 1'b0;
    priv_key = 8'h00;
    ct_valid = 1'b0;
    ct_data = 8'h00;
    ct_last = 1'b0;
    pt_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 64'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check("idle_not_busy", busy, 0);

    // Basic message with cycle-level timing of the first byte.
    clear_scoreboard();
    behav = B_OK;
    start_msg(8'h5A);
    send_byte(8'h5A, 8'h32, 1'b0, 1'b1);
    check("strobe_cycle", {core_inputs_valid, core_mode}, {1'b1, 2'b11});
    check("strobe_operands", {core_data_input, core_key_input}, 16'h325A);
    @(negedge clk);
    check("wait_no_strobe", {core_inputs_valid, core_mode, pt_valid}, {1'b0, 2'b11, 1'b0});
    @(negedge clk);
    check("push_and_ready", {pt_valid, ct_ready}, 2'b11);
    send_byte(8'h5A, 8'h3F, 1'b1, 1'b1);
    wait_done("basic_done", 50);
    check("basic_got_n", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("basic_pt0", got_q[0], 9'h068);
      check("basic_pt1", got_q[1], 9'h165);
    end
    check("basic_count", char_count, 2);
    check("basic_done_once", done_cnt, 1);
    check("basic_errs", {err_char, err_key, err_timeout}, 3'b000);
    check("basic_idle", busy, 0);

    // Backpressure: 12 bytes, consumer stalled until the FIFO fills.
    clear_scoreboard();
    pt_ready = 1'b0;
    start_msg(8'hC3);
    for (int i = 0; i < 8; i++) send_byte(8'hC3, 8'(i * 17 + 1), 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("bp_ct_ready_low", ct_ready, 0);
    check("bp_pt_hold", {pt_valid, pt_data}, {1'b1, 8'hC2});
    check("bp_count8", char_count, 8);
    pt_ready = 1'b1;
    for (int i = 8; i < 12; i++) send_byte(8'hC3, 8'(i * 17 + 1), i == 11, 1'b1);
    wait_done("bp_done", 100);
    check("bp_got_n", got_q.size(), 12);
    check("bp_all_matched", exp_q.size(), 0);
    check("bp_count12", char_count, 12);

    // Invalid ciphertext character on the 2nd of 3 bytes.
    clear_scoreboard();
    behav = B_CTXT;
    err_at = 1;
    start_msg(8'h11);
    send_byte(8'h11, 8'hA0, 1'b0, 1'b1);
    send_byte(8'h11, 8'hB1, 1'b0, 1'b0);
    send_byte(8'h11, 8'hC2, 1'b1, 1'b1);
    wait_done("ctxt_done", 50);
    check("ctxt_got_n", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("ctxt_pt0", got_q[0], 9'h0B1);
      check("ctxt_pt1", got_q[1], 9'h1D3);
    end
    check("ctxt_flags", {err_char, err_key, err_timeout}, 3'b100);
    check("ctxt_count", char_count, 2);
    check("ctxt_done_once", done_cnt, 1);

    // Secret-key error on the first byte aborts without pushing.
    clear_scoreboard();
    behav = B_KEY;
    err_at = 0;
    start_msg(8'h42);
    check("start_clears_err", err_char, 0);
    send_byte(8'h42, 8'h10, 1'b0, 1'b0);
    wait_done("key_done", 20);
    check("key_flags", {err_char, err_key, err_timeout}, 3'b010);
    check("key_no_push", {pt_valid, char_count}, 17'h0);
    check("key_done_once", done_cnt, 1);

    // Core never answers: 1 FIRE cycle then 15 WAIT cycles, then timeout.
    clear_scoreboard();
    behav = B_NONE;
    start_msg(8'h33);
    send_byte(8'h33, 8'h44, 1'b0, 1'b0);
    n = 0;
    while (core_mode == 2'b11 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("timeout_decrypt_cycles", n, 16);
    check("timeout_flags", {err_char, err_key, err_timeout}, 3'b001);
    check("timeout_done_now", done, 1);
    @(negedge clk);
    check("timeout_done_once", done_cnt, 1);
    check("timeout_idle", busy, 0);

    // Reset during WAIT; a start while busy must not change the key.
    clear_scoreboard();
    start_msg(8'h77);
    check("new_start_clears_timeout", err_timeout, 0);
    send_byte(8'h77, 8'h01, 1'b0, 1'b0);
    start = 1'b1;
    priv_key = 8'hEE;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_ignored", {busy, core_mode, core_key_input}, {1'b1, 2'b11, 8'h77});
    #1 rst_n = 1'b1;
    #1 check("midop_reset_outputs", out_vec(), 64'h0);
    @(negedge clk);
    rst_n = 1'b0;
    clear_scoreboard();
    behav = B_OK;
    @(negedge clk);
    check("post_reset_idle", {busy, pt_valid}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
